// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a single-entry holding register and error flags.
// Define UART_RX_PARITY_EN to expect one even-parity bit after data bit 7.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_d;
    logic [7:0]       shift, shift_d;
    logic             rx_meta, rx_sync, rx_prev;
    logic             load_byte, drop_byte, stop_low;
    logic             byte_ok;

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_d, par_mismatch;
    assign byte_ok = !par_bad;
`else
    assign byte_ok    = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d   = state;
        cnt_d     = cnt + 1'b1;
        bit_d     = bit_idx;
        shift_d   = shift;
        load_byte = 1'b0;
        drop_byte = 1'b0;
        stop_low  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad;
        par_mismatch = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (rx_prev && !rx_sync) state_d = START;
            end
            START: begin
                // Mid-start-bit check: a line already back high was only a glitch.
                if (cnt == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift[7:1]};
                    bit_d   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    if ((^shift) != rx_sync) begin
                        par_bad_d    = 1'b1;
                        par_mismatch = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (cnt == LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rx_sync) begin
                        stop_low = 1'b1;
                    end else if (byte_ok) begin
                        if (!rx_valid || rx_ready) load_byte = 1'b1;
                        else                       drop_byte = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_d;
            shift     <= shift_d;
            frame_err <= stop_low;
            if (drop_byte) overrun <= 1'b1;
            // A reload in the same cycle as a consume wins over the clear.
            if (load_byte) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_d;
            parity_err <= par_mismatch;
`endif
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200 baud); legal values >= 4.
REQ-002 SHALL provide port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port rx  input  1  asynchronous serial line, idle high, 8N1 frames, LSB first.
REQ-005 SHALL provide port rx_data  output  8  received byte, stable while rx_valid=1.
REQ-006 SHALL provide port rx_valid  output  1  holding register contains an unconsumed byte.
REQ-007 SHALL provide port rx_ready  input  1  consumer accepts rx_data in a cycle with rx_valid=1.
REQ-008 SHALL provide port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL provide port parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).
REQ-010 SHALL provide port overrun  output  1  sticky: a completed byte was dropped because the holding register was full.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (Configuration-dependent), STOP.
REQ-013 IDLE: SHALL leave on a synchronized high-to-low transition and enter START with baud counter cleared.
REQ-014 START: after CLKS_PER_BIT/2 cycles SHALL resample; low -> DATA; high -> glitch, return to IDLE with no output activity.
REQ-015 DATA: SHALL sample every CLKS_PER_BIT cycles, shifting bits LSB first; after bit 7 SHALL go to PARITY if enabled, else STOP.
REQ-016 STOP: SHALL sample once CLKS_PER_BIT cycles after the last data/parity sample, then return to IDLE.
REQ-017 Stop sample high with rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: SHALL load rx_data and set rx_valid on the following edge.
REQ-018 Stop sample high with rx_valid=1 and rx_ready=0: SHALL drop the new byte, keep rx_data unchanged and set overrun.
REQ-019 Stop sample low: SHALL pulse frame_err for exactly one cycle and discard the byte; a new frame requires the line to return high first.
REQ-020 rx_valid SHALL clear on the edge after a cycle with rx_valid=1 and rx_ready=1, unless REQ-017 reloads in that cycle.
REQ-021 rx_data SHALL NOT change while rx_valid=1 except through a REQ-017 reload.
REQ-022 Baud counter width SHALL be $clog2(CLKS_PER_BIT); it SHALL wrap to 0 at each sample point.
REQ-023 Latency: rx_valid SHALL rise 1 cycle after the stop-bit sample point (about 9.5 bit times + 3 cycles after the rx falling edge).

Reset
REQ-024 On reset assertion, state SHALL go to IDLE immediately; rx_data=8'h00, rx_valid=0, frame_err=0, parity_err=0, overrun=0, counters=0, synchronizer=1.
REQ-025 Reset mid-frame SHALL abandon the frame; after release the block SHALL wait for a fresh falling edge.
REQ-026 overrun SHALL clear only on reset.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: one even-parity bit SHALL follow bit 7 in PARITY state; a mismatch SHALL pulse parity_err for 1 cycle, discard the byte, and still consume the stop bit.
REQ-028 Macro UART_RX_PARITY_EN undefined: PARITY state and parity logic SHALL be absent; parity_err SHALL be tied to 0; the port SHALL remain present.

Verification (CLKS_PER_BIT=8)
REQ-029 Send 8N1 frame 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid high exactly 1 cycle, no error flags.
REQ-030 Drive rx low for 2 cycles, then high -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-031 Send 0x3C with stop bit 0 -> frame_err 1-cycle pulse, rx_valid stays 0; next valid frame 0x11 -> rx_data=0x11.
REQ-032 Send 0x01 then 0x02 with rx_ready=0 -> rx_data=0x01, rx_valid=1, overrun=1; assert rx_ready -> rx_valid clears, overrun stays 1.
REQ-033 Assert reset during data bit 4, release, send 0x5A -> only 0x5A delivered, no error flags.
REQ-034 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; with parity bit 1 -> rx_data=0x07.
